pll_lock_ctrl: RTL and testbench

- Sequences the behavioural clock multiplier (`pll`):
  - enables it;
  - waits a settle time;
  - measures its output frequency against the system clock;
  - declares lock, then gates the multiplied clock onto downstream logic.
- Sits between the top-level enable/status registers and the `pll` instance.
- Lock is lost, and the output gated off, when a later measurement falls outside tolerance.

---
 rtl/pll_lock_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: lock sequencer for the behavioural clock multiplier.
//
// Enables the PLL, waits a fixed settle time, then measures the PLL output
// frequency over back-to-back windows of system-clock cycles. It declares lock
// after LOCK_WINDOWS consecutive in-tolerance windows and then gates the
// multiplied clock downstream. It raises a sticky fault after MAX_FAIL
// consecutive bad windows while acquiring.
//
// Optional feature macro: PLL_LOCK_RELOCK_EN
//   defined   - a bad window while locked returns to MEASURE and re-acquires
//   undefined - a bad window while locked goes to FAULT (cleared by en=0)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   level request to run the PLL
//   pll_clk   in   PLL output clock, asynchronous to clk
//   pll_en    out  PLL enable
//   gate_en   out  clock-gate enable for the multiplied clock
//   locked    out  lock status
//   fault     out  sticky acquisition failure
//   edge_cnt  out  edge count of the last completed window (saturating)
//   state     out  FSM state (OFF=0 SETTLE=1 MEASURE=2 LOCKED=3 FAULT=4)
module pll_lock_ctrl #(
    parameter int WINDOW       = 64,
    parameter int EXPECT       = 8,
    parameter int TOL          = 1,
    parameter int SETTLE       = 32,
    parameter int LOCK_WINDOWS = 3,
    parameter int MAX_FAIL     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       pll_clk,
    output logic       pll_en,
    output logic       gate_en,
    output logic       locked,
    output logic       fault,
    output logic [7:0] edge_cnt,
    output logic [2:0] state
);

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_LOCKED  = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    localparam int WIN_W  = $clog2(WINDOW);
    localparam int SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WINDOW - 1);
    localparam logic [SET_W-1:0]  SET_LAST    = SET_W'(SETTLE - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST   = GOOD_W'(LOCK_WINDOWS - 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST   = FAIL_W'(MAX_FAIL - 1);
    // Lower bound clamps at zero rather than wrapping when TOL > EXPECT.
    localparam logic [31:0]       BOUND_LO    = (TOL > EXPECT) ? 32'd0 : 32'(EXPECT - TOL);
    localparam logic [31:0]       BOUND_HI    = 32'(EXPECT + TOL);

    logic [2:0]        pll_sync;   // [0] metastable, [1] synced, [2] previous
    logic              pll_rise;
    logic [WIN_W-1:0]  win_cnt;
    logic [SET_W-1:0]  settle_cnt;
    logic [7:0]        cnt_acc;
    logic [7:0]        win_total;
    logic [GOOD_W-1:0] good_cnt;
    logic [FAIL_W-1:0] fail_cnt;
    logic              terminal;
    logic              win_good;

    // The synchronizer runs in every state so that a level held across the
    // SETTLE->MEASURE boundary is never mistaken for a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pll_sync <= '0;
        else        pll_sync <= {pll_sync[1:0], pll_clk};
    end

    assign pll_rise  = pll_sync[1] & ~pll_sync[2];
    assign terminal  = (win_cnt == WIN_LAST);
    // A rise on the terminal cycle is folded into the window it closes.
    assign win_total = (pll_rise && cnt_acc != 8'hFF) ? cnt_acc + 8'd1 : cnt_acc;
    assign win_good  = (32'(win_total) >= BOUND_LO) && (32'(win_total) <= BOUND_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_OFF;
            settle_cnt <= '0;
            win_cnt    <= '0;
            cnt_acc    <= '0;
            good_cnt   <= '0;
            fail_cnt   <= '0;
            edge_cnt   <= '0;
        end else if (!en) begin
            // edge_cnt intentionally keeps the last completed measurement.
            state      <= S_OFF;
            settle_cnt <= '0;
            win_cnt    <= '0;
            cnt_acc    <= '0;
            good_cnt   <= '0;
            fail_cnt   <= '0;
        end else begin
            case (state)
                S_OFF: begin
                    state      <= S_SETTLE;
                    settle_cnt <= '0;
                end
                S_SETTLE: begin
                    if (settle_cnt == SET_LAST) begin
                        state      <= S_MEASURE;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_MEASURE, S_LOCKED: begin
                    if (terminal) begin
                        win_cnt  <= '0;
                        cnt_acc  <= '0;
                        edge_cnt <= win_total;
                        if (state == S_LOCKED) begin
                            if (!win_good) begin
`ifdef PLL_LOCK_RELOCK_EN
                                state <= S_MEASURE;
`else
                                state <= S_FAULT;
`endif
                                good_cnt <= '0;
                                fail_cnt <= '0;
                            end
                        end else if (win_good) begin
                            fail_cnt <= '0;
                            if (good_cnt == GOOD_LAST) begin
                                state    <= S_LOCKED;
                                good_cnt <= '0;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else begin
                            good_cnt <= '0;
                            if (fail_cnt == FAIL_LAST) begin
                                state    <= S_FAULT;
                                fail_cnt <= '0;
                            end else begin
                                fail_cnt <= fail_cnt + 1'b1;
                            end
                        end
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                        cnt_acc <= win_total;
                    end
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_OFF;
            endcase
        end
    end

    assign pll_en  = (state == S_SETTLE) || (state == S_MEASURE) || (state == S_LOCKED);
    assign locked  = (state == S_LOCKED);
    assign gate_en = (state == S_LOCKED);
    assign fault   = (state == S_FAULT);

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl with default parameters.
// pll_clk comes from a 64-cycle periodic pattern with n rises per period, so
// every 64-cycle window sees exactly n edges whatever its alignment. Every
// start() re-phases the pattern so rises land at cycles k = 5 mod 8 (for n=8),
// away from the window boundaries at cycles 32 + 64*w.
`timescale 1ns/1ps
module tb_pll_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       pll_clk = 1'b0;
    logic       pll_en, gate_en, locked, fault;
    logic [7:0] edge_cnt;
    logic [2:0] state;

    pll_lock_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pll_clk(pll_clk),
        .pll_en(pll_en), .gate_en(gate_en), .locked(locked), .fault(fault),
        .edge_cnt(edge_cnt), .state(state)
    );

    always #5 clk = ~clk;

    int   gen_n = 0;
    logic use_man = 1'b1;
    logic man_lvl = 1'b0;
    int   restart_req = 0;
    int   restart_seen = 0;
    int   phase = 0;

    function automatic logic pat_hit(int n, int p);
        for (int i = 0; i < n; i++)
            if (p == i * 64 / n || p == i * 64 / n + 1) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin : gen
        int p;
        p = (restart_req != restart_seen) ? 4 : phase;
        restart_seen <= restart_req;
        pll_clk      <= use_man ? man_lvl : pat_hit(gen_n, p);
        phase        <= (p + 1) % 64;
    end

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(int c);
        while (cyc < c) step();
    endtask

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        en = 1'b0;
        use_man = 1'b1;
        man_lvl = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    // Called just after a rising edge; edge 1 is the first to see en=1.
    task automatic start(int n, logic man);
        gen_n = n;
        use_man = man;
        restart_req++;
        en = 1'b1;
        cyc = 0;
    endtask

    typedef struct {
        int   n;
        int   exp_state;
        logic exp_locked;
        logic exp_fault;
        logic exp_pll_en;
        int   exp_ec;
    } vec_t;

    vec_t vecs[6];
    int   exp_after_drop;
    logic exp_pll_after_drop;
    int   prev_state;
    logic seq_ok;

    initial begin
        vecs[0] = '{8,  3, 1'b1, 1'b0, 1'b1, 8};
        vecs[1] = '{7,  3, 1'b1, 1'b0, 1'b1, 7};
        vecs[2] = '{9,  3, 1'b1, 1'b0, 1'b1, 9};
        vecs[3] = '{6,  4, 1'b0, 1'b1, 1'b0, 6};
        vecs[4] = '{10, 4, 1'b0, 1'b1, 1'b0, 10};
        vecs[5] = '{0,  4, 1'b0, 1'b1, 1'b0, 0};
`ifdef PLL_LOCK_RELOCK_EN
        exp_after_drop = 2;
        exp_pll_after_drop = 1'b1;
`else
        exp_after_drop = 4;
        exp_pll_after_drop = 1'b0;
`endif

        // reset state
        #12;
        chk("rst_state", int'(state), 0);
        chk("rst_pll_en", int'(pll_en), 0);
        chk("rst_gate_en", int'(gate_en), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_edge_cnt", int'(edge_cnt), 0);
        do_reset();

        // lock latency and state progression, then lose lock
        start(8, 1'b0);
        chk("lat_state_c0", int'(state), 0);
        prev_state = 0;
        seq_ok = 1'b1;
        while (cyc < 225) begin
            step();
            if (int'(state) < prev_state || int'(state) > prev_state + 1) seq_ok = 1'b0;
            prev_state = int'(state);
            if (cyc == 1)   chk("lat_state_c1", int'(state), 1);
            if (cyc == 1)   chk("lat_pll_en_c1", int'(pll_en), 1);
            if (cyc == 32)  chk("lat_state_c32", int'(state), 1);
            if (cyc == 33)  chk("lat_state_c33", int'(state), 2);
            if (cyc == 97)  chk("lat_ec_w0", int'(edge_cnt), 8);
            if (cyc == 224) chk("lat_locked_c224", int'(locked), 0);
        end
        chk("lat_seq_0123", int'(seq_ok), 1);
        chk("lat_state_c225", int'(state), 3);
        chk("lat_locked_c225", int'(locked), 1);
        chk("lat_gate_c225", int'(gate_en), 1);
        chk("lat_ec_c225", int'(edge_cnt), 8);
        use_man = 1'b1;
        man_lvl = 1'b0;
        run_to(288);
        chk("stop_locked_c288", int'(locked), 1);
        run_to(289);
        chk("stop_ec", int'(edge_cnt), 0);
        chk("stop_locked", int'(locked), 0);
        chk("stop_gate_en", int'(gate_en), 0);
        chk("stop_state", int'(state), exp_after_drop);
        chk("stop_pll_en", int'(pll_en), int'(exp_pll_after_drop));

        // table: edges per window vs. final outcome after 300 cycles
        for (int v = 0; v < 6; v++) begin
            do_reset();
            start(vecs[v].n, 1'b0);
            run_to(300);
            chk($sformatf("vec%0d_state", v), int'(state), vecs[v].exp_state);
            chk($sformatf("vec%0d_locked", v), int'(locked), int'(vecs[v].exp_locked));
            chk($sformatf("vec%0d_gate_en", v), int'(gate_en), int'(vecs[v].exp_locked));
            chk($sformatf("vec%0d_fault", v), int'(fault), int'(vecs[v].exp_fault));
            chk($sformatf("vec%0d_pll_en", v), int'(pll_en), int'(vecs[v].exp_pll_en));
            chk($sformatf("vec%0d_edge_cnt", v), int'(edge_cnt), vecs[v].exp_ec);
        end

        // alternating good/bad windows never lock nor fault
        do_reset();
        start(8, 1'b0);
        for (int w = 0; w < 8; w++) begin
            run_to(31 + 64 * w);
            use_man = (w % 2 == 1);
            man_lvl = 1'b0;
            run_to(97 + 64 * w);
            chk($sformatf("alt_w%0d_ec", w), int'(edge_cnt), (w % 2 == 1) ? 0 : 8);
            chk($sformatf("alt_w%0d_state", w), int'(state), 2);
            chk($sformatf("alt_w%0d_fault", w), int'(fault), 0);
        end

        // en drop mid-MEASURE, then reset mid-window while locked
        do_reset();
        start(8, 1'b0);
        run_to(120);
        chk("drop_pre_state", int'(state), 2);
        en = 1'b0;
        step();
        chk("drop_state", int'(state), 0);
        chk("drop_pll_en", int'(pll_en), 0);
        chk("drop_gate_en", int'(gate_en), 0);
        chk("drop_locked", int'(locked), 0);
        chk("drop_fault", int'(fault), 0);
        chk("drop_ec_kept", int'(edge_cnt), 8);
        step();
        start(8, 1'b0);
        run_to(225);
        chk("relock_locked", int'(locked), 1);
        run_to(250);
        rst_n = 1'b0;
        #2;
        chk("arst_state", int'(state), 0);
        chk("arst_locked", int'(locked), 0);
        chk("arst_gate_en", int'(gate_en), 0);
        chk("arst_pll_en", int'(pll_en), 0);
        chk("arst_ec", int'(edge_cnt), 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start(8, 1'b0);
        while (cyc < 33) begin
            step();
            if (cyc == 1)  chk("rest_state_c1", int'(state), 1);
            if (cyc == 32) chk("rest_state_c32", int'(state), 1);
        end
        chk("rest_state_c33", int'(state), 2);

        // pll_clk held high through SETTLE, then 5 pulses in the first window
        do_reset();
        man_lvl = 1'b1;
        start(0, 1'b1);
        run_to(33);
        chk("hold_state_c33", int'(state), 2);
        for (int i = 0; i < 5; i++) begin
            man_lvl = 1'b0;
            step();
            step();
            man_lvl = 1'b1;
            step();
            step();
        end
        man_lvl = 1'b0;
        run_to(96);
        chk("hold_ec_c96", int'(edge_cnt), 0);
        run_to(97);
        chk("hold_ec_w0", int'(edge_cnt), 5);
        chk("hold_state_w0", int'(state), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
